i_decode: RTL and testbench



---
 rtl/i_decode_pkg.sv | 70 +++++++
 rtl/i_decode_regfile.sv | 38 +++
 rtl/i_decode.sv | 106 ++++++++++
 tb/tb_i_decode.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/i_decode_pkg.sv
// Shared defines for the LEGv8 decode stage: widths, opcode constants,
// ALU-operation classes and the packed control-signal bundle.
package i_decode_pkg;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;
    localparam int NUM_REGS  = 32;
    localparam int REG_AW    = 5;

    localparam logic [REG_AW-1:0] XZR = 5'd31;

    // Full 11-bit opcodes
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    // Short opcodes, matched on the top bits of the instruction only
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    typedef enum logic [1:0] {
        ALU_OP_MEM   = 2'b00,   // address add for loads/stores
        ALU_OP_CBZ   = 2'b01,   // pass-through / zero test
        ALU_OP_RTYPE = 2'b10    // function taken from the opcode
    } alu_op_t;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_RTYPE,
        CLS_LDUR,
        CLS_STUR,
        CLS_CBZ,
        CLS_B
    } instr_class_t;

    typedef struct packed {
        logic    reg2_loc;
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    uncondbranch;
        alu_op_t alu_op;
    } ctrl_t;

    // Classify an instruction from its 11 opcode bits. The short CBZ and B
    // encodings do not overlap any of the full-width opcodes.
    function automatic instr_class_t classify(input logic [10:0] op);
        instr_class_t cls;
        cls = CLS_NONE;
        if (op[10:3] == OP_CBZ) begin
            cls = CLS_CBZ;
        end else if (op[10:5] == OP_B) begin
            cls = CLS_B;
        end else begin
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_ORR: cls = CLS_RTYPE;
                OP_LDUR:                        cls = CLS_LDUR;
                OP_STUR:                        cls = CLS_STUR;
                default:                        cls = CLS_NONE;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/i_decode_regfile.sv
// 32 x 64-bit register file: two asynchronous read ports, one synchronous
// write port. X31 is the zero register; it always reads 0 and ignores writes.
module regfile
    import i_decode_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] read_addr1,
    input  logic [REG_AW-1:0] read_addr2,
    input  logic [REG_AW-1:0] write_addr,
    input  logic              write_en,
    input  logic [WORD-1:0]   write_data,
    output logic [WORD-1:0]   read_data1,
    output logic [WORD-1:0]   read_data2
);

    logic [WORD-1:0] regs [NUM_REGS];

    // Reset loads X[i] = i (X31 = 0); otherwise commit one write per edge.
    // NOTE: this array is reset on purpose -- software relies on the X[i] = i
    // image, so it cannot map to a RAM macro without a separate init sequence.
    // NOTE: sequential state uses non-blocking assignments so every reader in
    // the same edge sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == int'(XZR)) ? '0 : WORD'(i);
            end
        end else if (write_en && (write_addr != XZR)) begin
            regs[write_addr] <= write_data;
        end
    end

    // Reads are asynchronous with no bypass; XZR is forced to zero.
    assign read_data1 = (read_addr1 == XZR) ? '0 : regs[read_addr1];
    assign read_data2 = (read_addr2 == XZR) ? '0 : regs[read_addr2];

endmodule

// File: rtl/i_decode.sv
// LEGv8 instruction-decode stage: control decode, immediate sign extension
// and register-file access for the single-cycle datapath.
module i_decode
    import i_decode_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_LEN-1:0] instruction,
    input  logic [WORD-1:0]      write_data,
    output logic [10:0]          opcode,
    output logic [WORD-1:0]      sign_extended_output,
    output logic                 reg2_loc,
    output logic                 uncondbranch,
    output logic                 branch,
    output logic                 mem_read,
    output logic                 mem_to_reg,
    output logic                 mem_write,
    output logic                 alu_src,
    output logic                 reg_write,
    output logic [1:0]           alu_op,
    output logic [WORD-1:0]      read_data1,
    output logic [WORD-1:0]      read_data2
);

    instr_class_t      cls;
    ctrl_t             ctrl;
    logic [WORD-1:0]   imm;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rm;
    logic [REG_AW-1:0] rd;

    assign opcode = instruction[31:21];
    assign cls    = classify(instruction[31:21]);

    // Control and immediate decode; unknown encodings leave everything zero.
    // NOTE: every output of this block is defaulted first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        ctrl = '0;
        imm  = '0;
        case (cls)
            CLS_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_OP_RTYPE;
            end
            CLS_LDUR: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALU_OP_MEM;
                imm = {{(WORD-9){instruction[20]}}, instruction[20:12]};
            end
            CLS_STUR: begin
                ctrl.reg2_loc  = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALU_OP_MEM;
                imm = {{(WORD-9){instruction[20]}}, instruction[20:12]};
            end
            CLS_CBZ: begin
                ctrl.reg2_loc = 1'b1;
                ctrl.branch   = 1'b1;
                ctrl.alu_op   = ALU_OP_CBZ;
                imm = {{(WORD-19){instruction[23]}}, instruction[23:5]};
            end
            CLS_B: begin
                ctrl.uncondbranch = 1'b1;
                imm = {{(WORD-26){instruction[25]}}, instruction[25:0]};
            end
            default: begin
                ctrl = '0;
                imm  = '0;
            end
        endcase
    end

    assign reg2_loc             = ctrl.reg2_loc;
    assign alu_src              = ctrl.alu_src;
    assign mem_to_reg           = ctrl.mem_to_reg;
    assign reg_write            = ctrl.reg_write;
    assign mem_read             = ctrl.mem_read;
    assign mem_write            = ctrl.mem_write;
    assign branch               = ctrl.branch;
    assign uncondbranch         = ctrl.uncondbranch;
    assign alu_op               = ctrl.alu_op;
    assign sign_extended_output = imm;

    // Stores and CBZ read their data register from the Rt field.
    assign rn = instruction[9:5];
    assign rd = instruction[4:0];
    assign rm = ctrl.reg2_loc ? instruction[4:0] : instruction[20:16];

    regfile u_regfile (
        .clk        (clk),
        .reset      (reset),
        .read_addr1 (rn),
        .read_addr2 (rm),
        .write_addr (rd),
        .write_en   (ctrl.reg_write),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

endmodule

// File: tb/tb_i_decode.sv
// Directed self-checking bench for the LEGv8 decode stage.
module tb_i_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [63:0] write_data;
    logic [10:0] opcode;
    logic [63:0] sign_extended_output;
    logic        reg2_loc, uncondbranch, branch, mem_read, mem_to_reg;
    logic        mem_write, alu_src, reg_write;
    logic [1:0]  alu_op;
    logic [63:0] read_data1, read_data2;

    int checks = 0;
    int errors = 0;

    // {reg2_loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
    //  branch, uncondbranch, alu_op}
    logic [9:0] ctrl_vec;
    assign ctrl_vec = {reg2_loc, alu_src, mem_to_reg, reg_write, mem_read,
                       mem_write, branch, uncondbranch, alu_op};

    localparam logic [9:0] C_RTYPE = 10'b0001000010;
    localparam logic [9:0] C_LDUR  = 10'b0111100000;
    localparam logic [9:0] C_STUR  = 10'b1100010000;
    localparam logic [9:0] C_CBZ   = 10'b1000001001;
    localparam logic [9:0] C_B     = 10'b0000000100;
    localparam logic [9:0] C_NONE  = 10'b0000000000;

    i_decode dut (
        .clk                  (clk),
        .reset                (reset),
        .instruction          (instruction),
        .write_data           (write_data),
        .opcode               (opcode),
        .sign_extended_output (sign_extended_output),
        .reg2_loc             (reg2_loc),
        .uncondbranch         (uncondbranch),
        .branch               (branch),
        .mem_read             (mem_read),
        .mem_to_reg           (mem_to_reg),
        .mem_write            (mem_write),
        .alu_src              (alu_src),
        .reg_write            (reg_write),
        .alu_op               (alu_op),
        .read_data1           (read_data1),
        .read_data2           (read_data2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Encoders for the instruction formats used below.
    function automatic logic [31:0] enc_r(input logic [10:0] op, input int rm,
                                          input int rn, input int rd);
        return {op, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
    endfunction

    function automatic logic [31:0] enc_d(input logic [10:0] op, input int off,
                                          input int rn, input int rt);
        return {op, 9'(off), 2'b00, 5'(rn), 5'(rt)};
    endfunction

    function automatic logic [31:0] enc_cbz(input int off, input int rt);
        return {8'b10110100, 19'(off), 5'(rt)};
    endfunction

    function automatic logic [31:0] enc_b(input int off);
        return {6'b000101, 26'(off)};
    endfunction

    // Drive one instruction at the falling edge; outputs settle before the
    // next rising edge, where any write commits.
    task automatic apply(input logic [31:0] instr, input logic [63:0] wd,
                         input logic rst);
        @(negedge clk);
        instruction = instr;
        write_data  = wd;
        reset       = rst;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        instruction = '0;
        write_data  = '0;

        apply(32'h0, 64'h0, 1'b1);
        apply(32'h0, 64'h0, 1'b1);

        // Reset image: X1 = 1, X30 = 30
        apply(enc_d(11'b11111000000, 0, 1, 30), 64'h0, 1'b0);
        check("rst_x1", read_data1, 64'd1);
        check("rst_x30", read_data2, 64'd30);

        // LDUR X9,[X22,#64]; X9 <- 0x1234 at the edge
        apply(32'hF84402C9, 64'h1234, 1'b0);
        check("ldur_opcode", {53'd0, opcode}, {53'd0, 11'b11111000010});
        check("ldur_ctrl", {54'd0, ctrl_vec}, {54'd0, C_LDUR});
        check("ldur_imm", sign_extended_output, 64'd64);
        check("ldur_rd1", read_data1, 64'd22);
        check("ldur_rd2", read_data2, 64'd4);

        // ADD X10,X19,X9; X10 <- 0xAAAA
        apply(enc_r(11'b10001011000, 9, 19, 10), 64'hAAAA, 1'b0);
        check("add_ctrl", {54'd0, ctrl_vec}, {54'd0, C_RTYPE});
        check("add_imm", sign_extended_output, 64'd0);
        check("add_rd1", read_data1, 64'd19);
        check("add_rd2", read_data2, 64'h1234);

        // SUB X11,X20,X10; X11 <- 0x5555
        apply(enc_r(11'b11001011000, 10, 20, 11), 64'h5555, 1'b0);
        check("sub_ctrl", {54'd0, ctrl_vec}, {54'd0, C_RTYPE});
        check("sub_rd1", read_data1, 64'd20);
        check("sub_rd2", read_data2, 64'hAAAA);

        // AND X12,X21,X11; X12 <- 0x77
        apply(enc_r(11'b10001010000, 11, 21, 12), 64'h77, 1'b0);
        check("and_ctrl", {54'd0, ctrl_vec}, {54'd0, C_RTYPE});
        check("and_rd1", read_data1, 64'd21);
        check("and_rd2", read_data2, 64'h5555);

        // ORR X13,X23,X12; X13 <- 0x88
        apply(enc_r(11'b10101010000, 12, 23, 13), 64'h88, 1'b0);
        check("orr_ctrl", {54'd0, ctrl_vec}, {54'd0, C_RTYPE});
        check("orr_rd1", read_data1, 64'd23);
        check("orr_rd2", read_data2, 64'h77);

        // STUR X11,[X22,#96] with write_data 0xFFFF: no write
        apply(enc_d(11'b11111000000, 96, 22, 11), 64'hFFFF, 1'b0);
        check("stur_ctrl", {54'd0, ctrl_vec}, {54'd0, C_STUR});
        check("stur_imm", sign_extended_output, 64'd96);
        check("stur_rd1", read_data1, 64'd22);
        check("stur_rd2", read_data2, 64'h5555);

        // CBZ X11,-5: X11 still 0x5555 after the store
        apply(enc_cbz(-5, 11), 64'h0, 1'b0);
        check("cbz_ctrl", {54'd0, ctrl_vec}, {54'd0, C_CBZ});
        check("cbz_imm_neg", sign_extended_output, 64'hFFFF_FFFF_FFFF_FFFB);
        check("cbz_rd2_x11", read_data2, 64'h5555);

        // CBZ X9,8
        apply(enc_cbz(8, 9), 64'h0, 1'b0);
        check("cbz_imm_pos", sign_extended_output, 64'd8);
        check("cbz_rd2_x9", read_data2, 64'h1234);

        // B 64 / B -55
        apply(enc_b(64), 64'h0, 1'b0);
        check("b_ctrl", {54'd0, ctrl_vec}, {54'd0, C_B});
        check("b_imm_pos", sign_extended_output, 64'd64);
        apply(enc_b(-55), 64'h0, 1'b0);
        check("b_ctrl_neg", {54'd0, ctrl_vec}, {54'd0, C_B});
        check("b_imm_neg", sign_extended_output, 64'hFFFF_FFFF_FFFF_FFC9);

        // Write to X31 is discarded
        apply(enc_r(11'b10001011000, 2, 1, 31), 64'hDEAD, 1'b0);
        apply(enc_d(11'b11111000000, 0, 31, 31), 64'h0, 1'b0);
        check("xzr_rd1", read_data1, 64'd0);
        check("xzr_rd2", read_data2, 64'd0);

        // Read-during-write: old value before the edge, new value after
        apply(enc_r(11'b10001011000, 7, 7, 7), 64'h42, 1'b0);
        check("rdw_old", read_data1, 64'd7);
        apply(enc_d(11'b11111000000, 0, 7, 7), 64'h0, 1'b0);
        check("rdw_new", read_data2, 64'h42);

        // Reset overrides a pending write and discards earlier writes
        apply(enc_r(11'b10001011000, 2, 1, 5), 64'hBEEF, 1'b1);
        apply(enc_d(11'b11111000000, 0, 9, 5), 64'h0, 1'b0);
        check("rst_wr_x5", read_data2, 64'd5);
        check("rst_wr_x9", read_data1, 64'd9);

        // Unknown encodings: everything zero
        apply(32'h0000_0000, 64'h0, 1'b0);
        check("unk0_ctrl", {54'd0, ctrl_vec}, {54'd0, C_NONE});
        check("unk0_imm", sign_extended_output, 64'd0);
        apply(32'hFFFF_FFFF, 64'h0, 1'b0);
        check("unk1_opcode", {53'd0, opcode}, {53'd0, 11'h7FF});
        check("unk1_ctrl", {54'd0, ctrl_vec}, {54'd0, C_NONE});
        check("unk1_imm", sign_extended_output, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
